// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths and serializer state type for the AES output path
package aes_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int AES_WORD_W    = 32;
    localparam int WORDS_PER_BLK = AES_BLK_W / AES_WORD_W;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } ser_state_t;

endpackage

// File: rtl/aes_blk_fifo.sv
// rtl/aes_blk_fifo.sv - DEPTH x DATA_W synchronous block FIFO with combinational head read
module aes_blk_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 128
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/aes_out_serializer.sv
// rtl/aes_out_serializer.sv - buffers AES result blocks and drains them as MSW-first words
module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int DATA_W = AES_BLK_W,
    parameter int WORD_W = AES_WORD_W,
    parameter int DEPTH  = 2
) (
    input  logic                     AES_clk,
    input  logic                     AES_rst,
    input  logic                     AES_data_out_valid,
    input  logic [DATA_W-1:0]        AES_data_out,
    output logic [WORD_W-1:0]        word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     word_last,
    output logic [$clog2(DEPTH):0]   blk_count,
    output logic                     buf_full,
    output logic                     overflow,
    input  logic                     overflow_clr
);

    localparam int NWORDS = DATA_W / WORD_W;
    localparam int IDX_W  = $clog2(NWORDS);
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    ser_state_t         r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_overflow;

    logic [DATA_W-1:0]  w_head;
    logic [DATA_W-1:0]  w_shifted;
    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_xfer;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign word_valid = (r_state == S_SEND);
    assign w_xfer     = word_valid & word_ready;
    assign w_pop      = w_xfer & (r_idx == LAST_IDX);
    assign w_push     = AES_data_out_valid & (~w_full | w_pop);
    assign w_drop     = AES_data_out_valid & w_full & ~w_pop;

    aes_blk_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_blk_fifo (
        .i_clk   (AES_clk),
        .i_rst   (AES_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (AES_data_out),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Word idx 0 is the most significant slice of the head block.
    assign w_shifted = w_head << (WORD_W * r_idx);
    assign word_out  = word_valid ? w_shifted[DATA_W-1 -: WORD_W] : '0;
    assign word_last = word_valid & (r_idx == LAST_IDX);
    assign blk_count = w_count;
    assign buf_full  = w_full;
    assign overflow  = r_overflow;

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (!w_empty) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            // Stay busy if a block remains after this pop, including one pushed now.
                            if (!((w_count > CNT_ONE) || w_push)) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_out_serializer.sv
// tb/tb_aes_out_serializer.sv - directed and randomized bench against a block-queue reference model
module tb_aes_out_serializer;

    logic         AES_clk = 1'b0;
    logic         AES_rst;
    logic         AES_data_out_valid;
    logic [127:0] AES_data_out;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic [1:0]   blk_count;
    logic         buf_full;
    logic         overflow;
    logic         overflow_clr;

    always #5 AES_clk = ~AES_clk;

    aes_out_serializer #(
        .DATA_W (128),
        .WORD_W (32),
        .DEPTH  (2)
    ) dut (
        .AES_clk            (AES_clk),
        .AES_rst            (AES_rst),
        .AES_data_out_valid (AES_data_out_valid),
        .AES_data_out       (AES_data_out),
        .word_out           (word_out),
        .word_valid         (word_valid),
        .word_ready         (word_ready),
        .word_last          (word_last),
        .blk_count          (blk_count),
        .buf_full           (buf_full),
        .overflow           (overflow),
        .overflow_clr       (overflow_clr)
    );

    int n_cmp = 0;
    int n_mis = 0;

    logic [127:0] m_q [$];
    int           m_widx;
    bit           m_valid;
    bit           m_ovf;
    logic [31:0]  acc_q [$];
    int           max_cnt;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_word();
        logic [127:0] b;
        if (!m_valid) return 32'h0;
        b = m_q[0] >> (32 * (3 - m_widx));
        return b[31:0];
    endfunction

    task automatic model_step(input bit v, input logic [127:0] d, input bit r, input bit clr, input bit rst);
        int old_size;
        bit was_valid;
        bit xfer;
        bit pop;
        bit room;
        if (rst) begin
            m_q.delete();
            m_widx  = 0;
            m_valid = 0;
            m_ovf   = 0;
            return;
        end
        old_size  = m_q.size();
        was_valid = m_valid;
        xfer      = m_valid && r;
        pop       = xfer && (m_widx == 3);
        room      = (old_size < 2) || pop;
        if (xfer) begin
            if (pop) begin
                void'(m_q.pop_front());
                m_widx = 0;
            end else begin
                m_widx++;
            end
        end
        if (v && room) m_q.push_back(d);
        if (v && !room) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (was_valid) m_valid = !pop || (m_q.size() > 0);
        else m_valid = (old_size > 0);
    endtask

    task automatic check_outputs();
        check_eq("word_valid", word_valid, m_valid);
        check_eq("word_last", word_last, m_valid && (m_widx == 3));
        check_eq("word_out", word_out, m_word());
        check_eq("blk_count", blk_count, m_q.size());
        check_eq("buf_full", buf_full, m_q.size() == 2);
        check_eq("overflow", overflow, m_ovf);
    endtask

    task automatic step(input bit v, input logic [127:0] d, input bit r, input bit clr, input bit rst);
        AES_data_out_valid = v;
        AES_data_out       = d;
        word_ready         = r;
        overflow_clr       = clr;
        AES_rst            = rst;
        if (word_valid === 1'b1 && r && !rst) acc_q.push_back(word_out);
        @(posedge AES_clk);
        model_step(v, d, r, clr, rst);
        @(negedge AES_clk);
        check_outputs();
        if (int'(blk_count) > max_cnt) max_cnt = int'(blk_count);
    endtask

    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] B1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] B2 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
    localparam logic [127:0] B3 = 128'hd7b26248_e8351227_5573a1e5_e8f263b3;
    localparam logic [127:0] B4 = 128'hf301a68a_9e9ffa50_844581d9_e290d818;

    initial begin
        logic [31:0]  e1 [4];
        logic [31:0]  e3 [8];
        logic [127:0] ra;
        logic [127:0] rb;
        int           found;

        e1 = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
        e3 = '{32'ha6f2daeb, 32'h140fa720, 32'h529e75d5, 32'h21cbc681,
               32'hd7b26248, 32'he8351227, 32'h5573a1e5, 32'he8f263b3};
        AES_rst = 1'b1;
        AES_data_out_valid = 1'b0;
        AES_data_out = '0;
        word_ready = 1'b0;
        overflow_clr = 1'b0;
        max_cnt = 0;

        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        check_eq("rst_word_out", word_out, 32'h0);

        // Single block, ready held high
        acc_q.delete();
        step(1, B1, 1, 0, 0);
        repeat (6) step(0, '0, 1, 0, 0);
        check_eq("t1_count", acc_q.size(), 4);
        for (int i = 0; i < acc_q.size() && i < 4; i++) check_eq($sformatf("t1_w%0d", i), acc_q[i], e1[i]);
        check_eq("t1_idle", word_valid, 1'b0);

        // Backpressure then toggled ready
        acc_q.delete();
        step(1, B1, 0, 0, 0);
        repeat (5) step(0, '0, 0, 0, 0);
        check_eq("t2_hold_word", word_out, 32'h00112233);
        check_eq("t2_hold_valid", word_valid, 1'b1);
        for (int i = 0; i < 12; i++) step(0, '0, (i % 2) == 0, 0, 0);
        check_eq("t2_count", acc_q.size(), 4);
        for (int i = 0; i < acc_q.size() && i < 4; i++) check_eq($sformatf("t2_w%0d", i), acc_q[i], e1[i]);

        // Back-to-back blocks
        acc_q.delete();
        max_cnt = 0;
        step(1, B2, 1, 0, 0);
        step(1, B3, 1, 0, 0);
        repeat (10) step(0, '0, 1, 0, 0);
        check_eq("t3_count", acc_q.size(), 8);
        for (int i = 0; i < acc_q.size() && i < 8; i++) check_eq($sformatf("t3_w%0d", i), acc_q[i], e3[i]);
        check_eq("t3_peak", max_cnt, 2);

        // Overflow drops third block
        acc_q.delete();
        ra = rnd_blk();
        rb = rnd_blk();
        step(1, ra, 0, 0, 0);
        step(1, rb, 0, 0, 0);
        step(1, B4, 0, 0, 0);
        check_eq("t4_ovf", overflow, 1'b1);
        check_eq("t4_full", buf_full, 1'b1);
        step(0, '0, 0, 1, 0);
        check_eq("t4_clr", overflow, 1'b0);
        repeat (12) step(0, '0, 1, 0, 0);
        check_eq("t4_count", acc_q.size(), 8);
        found = 0;
        foreach (acc_q[i]) if (acc_q[i] == 32'hf301a68a) found++;
        check_eq("t4_dropped", found, 0);

        // Full buffer, last-word pop coincides with a push
        ra = rnd_blk();
        rb = rnd_blk();
        step(1, ra, 0, 0, 0);
        step(1, rb, 0, 0, 0);
        repeat (3) step(0, '0, 1, 0, 0);
        check_eq("t5_last", word_last, 1'b1);
        step(1, rnd_blk(), 1, 0, 0);
        check_eq("t5_cnt", blk_count, 2'd2);
        check_eq("t5_ovf", overflow, 1'b0);
        repeat (10) step(0, '0, 1, 0, 0);

        // Reset mid-block
        step(1, rnd_blk(), 1, 0, 0);
        repeat (3) step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 1);
        check_eq("t6_valid", word_valid, 1'b0);
        check_eq("t6_cnt", blk_count, 2'd0);
        acc_q.delete();
        ra = rnd_blk();
        step(1, ra, 1, 0, 0);
        repeat (6) step(0, '0, 1, 0, 0);
        check_eq("t6_count", acc_q.size(), 4);
        if (acc_q.size() > 0) check_eq("t6_w0", acc_q[0], ra[127:96]);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 2) == 0, rnd_blk(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
Downstream stage of AES_top. Captures each 128-bit result block on AES_data_out_valid and buffers it in a small block FIFO. Drains each block as 32-bit words, most-significant word first, over a valid/ready handshake toward the system bus / output port. Absorbs back-to-back AES results while the consumer stalls, and flags any block dropped because the buffer was full.

Parameters:
DATA_W, 128, AES block width; fixed at 128, kept as a parameter for readability
WORD_W, 32, output word width; DATA_W must be an integer multiple of WORD_W
DEPTH, 2, number of 128-bit blocks buffered; power of two, at least 2

Ports:
AES_clk  in  1  single clock; all logic on rising edge
AES_rst  in  1  synchronous, active-high reset
AES_data_out_valid  in  1  one-cycle strobe from AES_top; result block present
AES_data_out  in  128  AES result block; sampled only when AES_data_out_valid=1
word_out  out  32  current output word
word_valid  out  1  word_out holds a valid word
word_ready  in  1  consumer accepts the word; a transfer occurs when word_valid & word_ready
word_last  out  1  high with the 4th (final) word of a block
blk_count  out  $clog2(DEPTH)+1  number of blocks held, including a partially sent block
buf_full  out  1  blk_count == DEPTH
overflow  out  1  sticky; a block was dropped
overflow_clr  in  1  clears overflow

Behaviour:
- Reset (AES_rst=1 at a clock edge):
  - word_valid, word_last, blk_count, buf_full and overflow go to 0; word_out goes to 0.
  - FIFO pointers and the word index are cleared.
  - A reset mid-block discards that block and every buffered block; no partial block survives.
- Capture:
  - On a cycle with AES_data_out_valid=1 and a slot free, the block is written at the write pointer and blk_count increments.
  - A slot counts as free when buf_full=0, or when the same cycle completes the last word of the head block.
  - Pop is evaluated before push in that case.
- Output FSM:
  - IDLE: word_valid=0. Moves to SEND when blk_count>0.
  - SEND: word_valid=1. word_out = head block bits [127-32*idx -: 32], where idx is a 2-bit index starting at 0.
  - On a transfer with idx<3: idx increments.
  - On a transfer with idx==3 (word_last=1):
    - the head block pops, idx returns to 0 and blk_count decrements;
    - stay in SEND if another block remains, otherwise go to IDLE.
- Latency:
  - A block captured at edge N into an empty buffer gives word_valid=1 with word 0 after edge N+1.
  - With word_ready held at 1, words follow on consecutive cycles, so one block takes 4 cycles.
  - Back-to-back blocks stream with no bubble.
- Handshake rules:
  - While word_valid=1 and word_ready=0, word_out and word_last hold stable.
  - word_valid never drops without a transfer, except on reset.
- Overflow:
  - AES_data_out_valid=1 with no free slot drops the incoming block; buffered contents are unchanged and overflow is set.
  - overflow_clr=1 clears overflow. If a drop happens in the same cycle as overflow_clr, set wins.
- blk_count on a simultaneous push and pop stays unchanged.
- Pointers wrap modulo DEPTH.
- word_last = word_valid & (idx==3).

Decomposition:
- Shared package aes_pkg:
  - AES_BLK_W=128 and AES_WORD_W=32 constants;
  - WORDS_PER_BLK=4;
  - the FSM state typedef {S_IDLE, S_SEND}.
- Natural sub-module: aes_blk_fifo, a DEPTH x 128 synchronous FIFO with push, pop, count, full and empty.
- The serializer FSM and word index stay in the top.

Test Plan:
1. Single block: after reset, pulse valid with 128'h00112233_44556677_8899aabb_ccddeeff and hold ready=1. Required: words 00112233, 44556677, 8899aabb, ccddeeff on consecutive cycles; word_last only on ccddeeff; then word_valid=0 and blk_count=0.
2. Backpressure: same block with ready=0 for 5 cycles. Required: word_out holds 00112233 with word_valid=1. Then toggle ready 1/0 and check that each word appears exactly once, in order.
3. Back-to-back: valid strobes carrying a6f2daeb_140fa720_529e75d5_21cbc681 then d7b26248_e8351227_5573a1e5_e8f263b3 on adjacent cycles, ready=1. Required: 8 contiguous words, no bubble; blk_count peaks at 2.
4. Overflow: ready=0 and 3 valid strobes, the third carrying f301a68a_9e9ffa50_844581d9_e290d818. Required: overflow=1, buf_full=1, and the third block is never output. Pulse overflow_clr; overflow returns to 0.
5. Full plus final pop: buffer full, then in one cycle a word_last transfer coincides with a new valid strobe. Required: the new block is accepted, blk_count stays 2, overflow stays 0.
6. Reset mid-block: assert AES_rst after 2 words are sent. Required: next cycle word_valid=0 and blk_count=0. A fresh block then starts from word 0.
